// File: rtl/stream_kernel_ctrl_pkg.sv
// Shared types and constants for the streaming kernel run controller.
package stream_kernel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int ERR_COUNT   = 0;
  localparam int ERR_EOT     = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_W       = 3;

  localparam int N_W_DEF     = 64;
  localparam int TAG_W_DEF   = 8;
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/stream_eot_monitor.sv
// Passive output-stream monitor: qualifies transfers, counts data tokens
// (saturating), and tracks the close token and any data arriving after it.
module stream_eot_monitor
  import stream_kernel_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_write,
  input  logic             i_full_n,
  input  logic             i_eot,
  output logic             o_xfer,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_eot_nxt,
  output logic             o_late_nxt
);

  logic [CNT_W-1:0] r_count;
  logic             r_eot_seen;
  logic             r_late;
  logic             w_xfer;

  assign w_xfer = i_en & i_write & i_full_n;
  assign o_xfer = w_xfer;

  // Next-state values are exported so the controller can capture a status
  // that already includes a transfer landing in the same cycle as ap_done.
  always_comb begin
    o_count_nxt = r_count;
    o_eot_nxt   = r_eot_seen;
    o_late_nxt  = r_late;
    if (i_clear) begin
      o_count_nxt = '0;
      o_eot_nxt   = 1'b0;
      o_late_nxt  = 1'b0;
    end else if (w_xfer) begin
      if (i_eot) begin
        o_eot_nxt = 1'b1;
      end else begin
        if (r_count != '1) o_count_nxt = r_count + 1'b1;
        if (r_eot_seen)    o_late_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_count    <= '0;
      r_eot_seen <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_count    <= o_count_nxt;
      r_eot_seen <= o_eot_nxt;
      r_late     <= o_late_nxt;
    end
  end

endmodule

// File: rtl/stream_kernel_run_ctrl.sv
// Sequences one ap_ctrl_hs streaming kernel invocation at a time and reports
// per-job token count/EOT status. Optional watchdog: STREAM_KERNEL_RUN_CTRL_WATCHDOG_EN.
module stream_kernel_run_ctrl
  import stream_kernel_ctrl_pkg::*;
#(
  parameter int N_W            = N_W_DEF,
  parameter int TAG_W          = TAG_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N_W-1:0]   cmd_n,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  input  logic             k_ap_idle,
  output logic [N_W-1:0]   k_n,
  input  logic             mon_write,
  input  logic             mon_full_n,
  input  logic             mon_eot,
  output logic             sts_valid,
  input  logic             sts_ready,
  output logic [TAG_W-1:0] sts_tag,
  output logic [CNT_W-1:0] sts_count,
  output logic [ERR_W-1:0] sts_err,
  output logic             busy
);

  localparam int CMP_W = (N_W > CNT_W) ? N_W : CNT_W;

  state_e           r_state;
  logic [TAG_W-1:0] r_tag;
  logic             w_accept;
  logic             w_mon_en;
  logic             w_xfer;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_eot_nxt;
  logic             w_late_nxt;
  logic             w_normal_done;
  logic             w_timeout;
  logic             w_to_report;
  logic [ERR_W-1:0] w_err;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE) | ~k_ap_idle;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_mon_en  = (r_state == START) | (r_state == RUN);

  stream_eot_monitor #(.CNT_W(CNT_W)) u_mon (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .i_clear     (w_accept),
    .i_en        (w_mon_en),
    .i_write     (mon_write),
    .i_full_n    (mon_full_n),
    .i_eot       (mon_eot),
    .o_xfer      (w_xfer),
    .o_count_nxt (w_count_nxt),
    .o_eot_nxt   (w_eot_nxt),
    .o_late_nxt  (w_late_nxt)
  );

  assign w_normal_done = ((r_state == START) & k_ap_ready & k_ap_done) |
                         ((r_state == RUN) & k_ap_done);

`ifdef STREAM_KERNEL_RUN_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            w_progress;

  assign w_progress = w_xfer | ((r_state == START) & k_ap_ready);
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle in START/RUN.
  assign w_timeout  = w_mon_en & ~w_progress & ~w_normal_done &
                      (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                 r_wd <= '0;
    else if (w_accept)             r_wd <= '0;
    else if (w_mon_en) r_wd <= w_progress ? '0 : r_wd + 1'b1;
  end
`else
  logic w_unused_wd;
  assign w_timeout   = 1'b0;
  assign w_unused_wd = w_xfer ^ (TIMEOUT_CYCLES > 0);
`endif

  assign w_to_report = w_mon_en & (w_normal_done | w_timeout);

  always_comb begin
    w_err              = '0;
    w_err[ERR_COUNT]   = (CMP_W'(w_count_nxt) != CMP_W'(k_n)) | w_late_nxt;
    w_err[ERR_EOT]     = ~w_eot_nxt;
    w_err[ERR_TIMEOUT] = w_timeout;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= IDLE;
      r_tag      <= '0;
      k_ap_start <= 1'b0;
      k_n        <= '0;
      sts_valid  <= 1'b0;
      sts_tag    <= '0;
      sts_count  <= '0;
      sts_err    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            k_n        <= cmd_n;
            r_tag      <= cmd_tag;
            k_ap_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (k_ap_ready) begin
            k_ap_start <= 1'b0;
            r_state    <= k_ap_done ? REPORT : RUN;
          end else if (w_timeout) begin
            k_ap_start <= 1'b0;
            r_state    <= REPORT;
          end
        end
        RUN: begin
          if (w_to_report) r_state <= REPORT;
        end
        REPORT: begin
          if (sts_ready) begin
            sts_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_to_report) begin
        sts_valid <= 1'b1;
        sts_tag   <= r_tag;
        sts_count <= w_count_nxt;
        sts_err   <= w_err;
      end
    end
  end

endmodule
